// File: rtl/vector_pkg.sv
// Shared sizing constants and FSM state encoding for the vector write-back serializer.
package vector_pkg;

  localparam int DATA_W = 32;
  localparam int ROW_W  = 4;
  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/lane_pick.sv
// Lowest-set-bit encoder: returns the index of the first pending lane and whether any lane is pending.
module lane_pick
  import vector_pkg::*;
#(
  parameter int N     = vector_pkg::LANES,
  parameter int IDX_W = $clog2(vector_pkg::LANES)
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the lowest set bit wins the last assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
    any = |mask;
  end

endmodule

// File: rtl/vector_wb_serializer.sv
// Captures a masked result row and writes its enabled lanes one cell per cycle, lowest lane first.
module vector_wb_serializer
  import vector_pkg::*;
#(
  parameter int DATA_W = vector_pkg::DATA_W,
  parameter int ROW_W  = vector_pkg::ROW_W,
  parameter int LANES  = vector_pkg::LANES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROW_W-1:0]        in_row,
  input  logic [LANES-1:0]        in_mask,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    writeEnable,
  output logic [ROW_W-1:0]        writeAddressR,
  output logic [$clog2(LANES)-1:0] writeAddressC,
  output logic [DATA_W-1:0]       writeData,
  output logic                    busy,
  output logic [ROW_W-1:0]        busy_row,
  output logic                    done
);

  localparam int IDX_W = $clog2(LANES);

  state_t             state, state_n;
  logic [LANES-1:0]   pend, pend_n;
  logic [ROW_W-1:0]   row_q;
  logic [DATA_W-1:0]  data_q [LANES];
  logic               zero_done;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               last;
  logic               accept;

  lane_pick #(.N(LANES), .IDX_W(IDX_W)) u_pick (
    .mask (pend),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Exactly one pending lane left: this is the final write of the row.
  assign last     = (state == ST_WRITE) && pick_any && ((pend & (pend - LANES'(1))) == '0);
  assign in_ready = !reset && ((state == ST_IDLE) || last);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    pend_n        = pend;
    writeEnable   = 1'b0;
    writeAddressR = '0;
    writeAddressC = '0;
    writeData     = '0;
    busy          = 1'b0;
    busy_row      = '0;
    done          = zero_done;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          pend_n = in_mask;
          if (|in_mask) state_n = ST_WRITE;
        end
      end
      ST_WRITE: begin
        writeEnable   = pick_any;
        writeAddressR = row_q;
        writeAddressC = pick_idx;
        writeData     = data_q[pick_idx];
        busy          = 1'b1;
        busy_row      = row_q;
        pend_n        = pend & ~(LANES'(1) << pick_idx);
        if (last) begin
          done = 1'b1;
          if (accept && |in_mask) pend_n = in_mask;
          else                    state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= '0;
      row_q     <= '0;
      zero_done <= 1'b0;
      for (int k = 0; k < LANES; k++) data_q[k] <= '0;
    end else begin
      pend      <= pend_n;
      zero_done <= accept && !(|in_mask);
      if (accept) begin
        row_q <= in_row;
        for (int k = 0; k < LANES; k++) data_q[k] <= in_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_vector_wb_serializer.sv
// Directed-vector bench for the vector write-back serializer with hand-computed per-cycle expectations.
module tb_vector_wb_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_row;
  logic [3:0]   in_mask;
  logic [127:0] in_data;
  logic         writeEnable;
  logic [3:0]   writeAddressR;
  logic [1:0]   writeAddressC;
  logic [31:0]  writeData;
  logic         busy;
  logic [3:0]   busy_row;
  logic         done;

  int n_vec = 0;
  int n_bad = 0;

  vector_wb_serializer dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_row        (in_row),
    .in_mask       (in_mask),
    .in_data       (in_data),
    .writeEnable   (writeEnable),
    .writeAddressR (writeAddressR),
    .writeAddressC (writeAddressC),
    .writeData     (writeData),
    .busy          (busy),
    .busy_row      (busy_row),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs for one cycle; address/data are expected 0 when no write is issued.
  task automatic cyc(input string tag, input logic we, input logic [3:0] r, input logic [1:0] c,
                     input logic [31:0] d, input logic dn, input logic rdy, input logic bsy);
    chk({tag, ".we"},    64'(writeEnable),   64'(we));
    chk({tag, ".row"},   64'(writeAddressR), we ? 64'(r) : 64'd0);
    chk({tag, ".lane"},  64'(writeAddressC), we ? 64'(c) : 64'd0);
    chk({tag, ".data"},  64'(writeData),     we ? 64'(d) : 64'd0);
    chk({tag, ".done"},  64'(done),          64'(dn));
    chk({tag, ".rdy"},   64'(in_ready),      64'(rdy));
    chk({tag, ".busy"},  64'(busy),          64'(bsy));
    chk({tag, ".brow"},  64'(busy_row),      bsy ? 64'(r) : 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] r, input logic [3:0] m,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
    in_valid = v;
    in_row   = r;
    in_mask  = m;
    in_data  = {d3, d2, d1, d0};
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 4'd5, 4'hF, 32'h1, 32'h2, 32'h3, 32'h4);
    tick();
    cyc("rst0", 0, 0, 0, 0, 0, 0, 0);
    tick();
    cyc("rst1", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    drive(1'b0, 4'd0, 4'h0, 0, 0, 0, 0);
    tick();
    cyc("idle", 0, 0, 0, 0, 0, 1, 0);

    // Full row: four writes in lane order.
    drive(1'b1, 4'd5, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    tick();
    drive(1'b0, 4'd0, 4'h0, 0, 0, 0, 0);
    cyc("full.c1", 1, 5, 0, 32'hA0, 0, 0, 1);
    tick(); cyc("full.c2", 1, 5, 1, 32'hA1, 0, 0, 1);
    tick(); cyc("full.c3", 1, 5, 2, 32'hA2, 0, 0, 1);
    tick(); cyc("full.c4", 1, 5, 3, 32'hA3, 1, 1, 1);
    tick(); cyc("full.c5", 0, 0, 0, 0, 0, 1, 0);

    // Sparse mask 1010.
    drive(1'b1, 4'd3, 4'hA, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
    tick();
    drive(1'b0, 4'd0, 4'h0, 0, 0, 0, 0);
    cyc("sparse.c1", 1, 3, 1, 32'hB1, 0, 0, 1);
    tick(); cyc("sparse.c2", 1, 3, 3, 32'hB3, 1, 1, 1);
    tick(); cyc("sparse.c3", 0, 0, 0, 0, 0, 1, 0);

    // Back-to-back: row 7 held valid, accepted on row 2's last write.
    drive(1'b1, 4'd2, 4'hF, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
    tick();
    drive(1'b1, 4'd7, 4'h3, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
    cyc("b2b.c1", 1, 2, 0, 32'hC0, 0, 0, 1);
    tick(); cyc("b2b.c2", 1, 2, 1, 32'hC1, 0, 0, 1);
    tick(); cyc("b2b.c3", 1, 2, 2, 32'hC2, 0, 0, 1);
    tick(); cyc("b2b.c4", 1, 2, 3, 32'hC3, 1, 1, 1);
    tick();
    drive(1'b0, 4'd0, 4'h0, 0, 0, 0, 0);
    cyc("b2b.c5", 1, 7, 0, 32'hD0, 0, 0, 1);
    tick(); cyc("b2b.c6", 1, 7, 1, 32'hD1, 1, 1, 1);
    tick(); cyc("b2b.c7", 0, 0, 0, 0, 0, 1, 0);

    // Empty mask: no writes, single done pulse.
    drive(1'b1, 4'd9, 4'h0, 32'hEE, 32'hEE, 32'hEE, 32'hEE);
    tick();
    drive(1'b0, 4'd0, 4'h0, 0, 0, 0, 0);
    cyc("zero.c1", 0, 0, 0, 0, 1, 1, 0);
    tick(); cyc("zero.c2", 0, 0, 0, 0, 0, 1, 0);

    // Reset after the second write abandons the row.
    drive(1'b1, 4'd6, 4'hF, 32'hE0, 32'hE1, 32'hE2, 32'hE3);
    tick();
    drive(1'b0, 4'd0, 4'h0, 0, 0, 0, 0);
    cyc("abort.c1", 1, 6, 0, 32'hE0, 0, 0, 1);
    tick(); cyc("abort.c2", 1, 6, 1, 32'hE1, 0, 0, 1);
    reset = 1'b1;
    tick(); cyc("abort.rst", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick(); cyc("abort.post1", 0, 0, 0, 0, 0, 1, 0);
    tick(); cyc("abort.post2", 0, 0, 0, 0, 0, 1, 0);

    // Inputs churn while busy; captured values must be used.
    drive(1'b1, 4'd4, 4'h5, 32'hF0, 32'hF1, 32'hF2, 32'hF3);
    tick();
    drive(1'b1, 4'd1, 4'h3, 32'h11, 32'h12, 32'h13, 32'h14);
    cyc("hold.c1", 1, 4, 0, 32'hF0, 0, 0, 1);
    drive(1'b1, 4'd8, 4'h3, 32'h81, 32'h82, 32'h83, 32'h84);
    tick(); cyc("hold.c2", 1, 4, 2, 32'hF2, 1, 1, 1);
    tick();
    drive(1'b0, 4'd0, 4'h0, 0, 0, 0, 0);
    cyc("hold.c3", 1, 8, 0, 32'h81, 0, 0, 1);
    tick(); cyc("hold.c4", 1, 8, 1, 32'h82, 1, 1, 1);
    tick(); cyc("hold.c5", 0, 0, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_wb_serializer.md
VECTOR_WB_SERIALIZER -- requirements
Module: vector_wb_serializer

Interface
REQ-001 Parameter: DATA_W, 32, lane width in bits.
REQ-002 Parameter: ROW_W, 4, row address width (16 vector rows).
REQ-003 Parameter: LANES, 4, lanes per row (lane index 2 bits).
REQ-004 Port: clk  in  1  single clock; all logic SHALL update on rising edge only.
REQ-005 Port: reset  in  1  reset, synchronous, active-high.
REQ-006 Port: in_valid  in  1  upstream result row valid.
REQ-007 Port: in_ready  out  1  block can accept a row this cycle.
REQ-008 Port: in_row  in  ROW_W  destination vector row.
REQ-009 Port: in_mask  in  LANES  per-lane write enable; bit k enables lane k.
REQ-010 Port: in_data  in  LANES*DATA_W  lane k at bits [32k+31:32k].
REQ-011 Port: writeEnable  out  1  single-cell write strobe to the vector register file.
REQ-012 Port: writeAddressR  out  ROW_W  row of current write.
REQ-013 Port: writeAddressC  out  2  lane of current write.
REQ-014 Port: writeData  out  DATA_W  data of current write.
REQ-015 Port: busy  out  1  a captured row still has pending writes.
REQ-016 Port: busy_row  out  ROW_W  row being written; upstream RAW interlock compares against it.
REQ-017 Port: done  out  1  one-cycle pulse when a row's writes complete.

Function
REQ-018 Acceptance SHALL occur exactly on a cycle with in_valid=1 and in_ready=1; row, mask, and data SHALL be captured into internal registers on that edge.
REQ-019 FSM states SHALL be IDLE and WRITE; in_ready SHALL be 1 in IDLE, 1 in WRITE only when exactly one pending mask bit remains, else 0; in_ready SHALL not depend on in_valid.
REQ-020 IDLE->WRITE on acceptance with nonzero mask; acceptance with mask 0000 SHALL remain IDLE, produce no write, and pulse done the following cycle.
REQ-021 In WRITE, each cycle SHALL issue exactly one write: writeEnable=1, writeAddressC = lowest set bit of pending mask, writeData = that lane's captured data, writeAddressR = captured row; that bit SHALL clear on the edge.
REQ-022 Writes SHALL issue in ascending lane order, on consecutive cycles, with count = popcount(mask); the first write SHALL appear the cycle after acceptance.
REQ-023 On the last write cycle done SHALL be 1; if an acceptance occurs that same cycle, the FSM SHALL stay in WRITE and the new row's first write SHALL appear next cycle (no bubble); otherwise WRITE->IDLE.
REQ-024 Input changes while not accepting SHALL not affect pending writes.
REQ-025 When writeEnable=0, writeAddressR, writeAddressC, and writeData SHALL be 0.
REQ-026 busy SHALL equal (state==WRITE); busy_row SHALL equal the captured row when busy, else 0.
REQ-027 No combinational path SHALL exist from in_* inputs to write outputs, busy, or done.

Reset
REQ-028 On a clock edge with reset=1: state IDLE, pending mask 0, all captured registers 0, done 0; writeEnable, addresses, writeData, busy, busy_row 0 from the following cycle.
REQ-029 While reset=1, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-030 Reset mid-transaction SHALL abandon all remaining writes; none SHALL issue after reset deasserts.

Structure
REQ-031 A shared package vector_pkg SHALL hold DATA_W, ROW_W, LANES, lane-index width, and the FSM state enum.
REQ-032 One sub-module, lane_pick, SHALL encode the lowest set bit of a LANES-bit mask to a 2-bit index plus an any-set flag.

Verification
REQ-033 Accept row 5, mask 1111, data 0xA0..0xA3 -> writes (5,0,0xA0),(5,1,0xA1),(5,2,0xA2),(5,3,0xA3) in cycles 1-4; done and in_ready high in cycle 4.
REQ-034 Accept row 3, mask 1010 -> exactly two writes (3,1),(3,3) on consecutive cycles; done on the second.
REQ-035 Row 2 mask 1111 with row 7 mask 0011 held valid -> row 7 accepted on row 2's fourth write; (7,0),(7,1) follow with no idle cycle.
REQ-036 Accept mask 0000 -> writeEnable never asserts; done pulses once the next cycle; busy stays 0.
REQ-037 Reset asserted after second write of a 1111 row -> no further writes; busy 0; in_ready 1 the cycle after reset deasserts.
REQ-038 Change in_data/in_row while busy with in_valid=1 -> in_ready 0 until last write; issued writes carry originally captured values.
